// File: rtl/sound_mixer_nch.sv
// N-channel piezo sound engine: prioritised burst-pattern tone channels over RPM-driven LFSR noise.
// Optional volume gating via a 4-bit PWM is enabled with `define SOUND_PWM_VOL_EN.
module sound_mixer_nch #(
    parameter int          N_CH        = 4,
    parameter int          DIV_W       = 20,
    parameter int          BURST_W     = 24,
    parameter int          RPM_W       = 14,
    parameter int          RPM_MIN     = 500,
    parameter int          NOISE_BASE  = 150000,
    parameter int          NOISE_SLOPE = 10,
    parameter int          NOISE_MIN   = 2000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RPM_W-1:0]        rpm,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH*DIV_W-1:0]   ch_half_period,
    input  logic [N_CH*BURST_W-1:0] ch_on_cyc,
    input  logic [N_CH*BURST_W-1:0] ch_off_cyc,
    input  logic [3:0]              vol,
    output logic                    piezo_out,
    output logic                    active_valid,
    output logic [CH_W-1:0]         active_ch
);

    localparam int               PW     = DIV_W + RPM_W;
    localparam logic [15:0]      SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [BURST_W-1:0] B_ONE = BURST_W'(1);
    localparam logic [DIV_W-1:0]   D_ONE = DIV_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} ch_state_t;

    ch_state_t          st        [N_CH];
    logic [DIV_W-1:0]   hp_q      [N_CH];
    logic [DIV_W-1:0]   tone_cnt  [N_CH];
    logic [BURST_W-1:0] on_q      [N_CH];
    logic [BURST_W-1:0] off_q     [N_CH];
    logic [BURST_W-1:0] burst_cnt [N_CH];
    logic [N_CH-1:0]    wave;
    logic [N_CH-1:0]    enter;
    logic [N_CH-1:0]    to_gap;

    // Burst-end decisions; enter also covers the first request from IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        enter  = '0;
        to_gap = '0;
        for (int i = 0; i < N_CH; i++) begin
            logic on_end;
            on_end    = (st[i] == S_ON) && (on_q[i] != '0) && (burst_cnt[i] == on_q[i] - B_ONE);
            to_gap[i] = on_end && (off_q[i] != '0);
            enter[i]  = ch_req[i] && ((st[i] == S_IDLE) ||
                                      (on_end && (off_q[i] == '0)) ||
                                      ((st[i] == S_GAP) && (burst_cnt[i] == off_q[i] - B_ONE)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset explicitly.
            for (int i = 0; i < N_CH; i++) begin
                st[i]        <= S_IDLE;
                hp_q[i]      <= '0;
                tone_cnt[i]  <= '0;
                on_q[i]      <= '0;
                off_q[i]     <= '0;
                burst_cnt[i] <= '0;
            end
            wave <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!ch_req[i]) begin
                    st[i]        <= S_IDLE;
                    tone_cnt[i]  <= '0;
                    burst_cnt[i] <= '0;
                    wave[i]      <= 1'b0;
                end else if (enter[i]) begin
                    st[i]        <= S_ON;
                    hp_q[i]      <= ch_half_period[i*DIV_W +: DIV_W];
                    on_q[i]      <= ch_on_cyc[i*BURST_W +: BURST_W];
                    off_q[i]     <= ch_off_cyc[i*BURST_W +: BURST_W];
                    tone_cnt[i]  <= '0;
                    burst_cnt[i] <= '0;
                    wave[i]      <= 1'b0;
                end else if (to_gap[i]) begin
                    st[i]        <= S_GAP;
                    tone_cnt[i]  <= '0;
                    burst_cnt[i] <= '0;
                    wave[i]      <= 1'b0;
                end else if (st[i] == S_ON) begin
                    burst_cnt[i] <= burst_cnt[i] + B_ONE;
                    if (hp_q[i] == '0) begin
                        wave[i] <= 1'b0;
                    end else if (tone_cnt[i] == hp_q[i] - D_ONE) begin
                        wave[i]     <= ~wave[i];
                        tone_cnt[i] <= '0;
                    end else begin
                        tone_cnt[i] <= tone_cnt[i] + D_ONE;
                    end
                end else if (st[i] == S_GAP) begin
                    burst_cnt[i] <= burst_cnt[i] + B_ONE;
                end
            end
        end
    end

    // Engine noise period, computed wide so a large rpm underflows cleanly into the clamp.
    logic [PW-1:0]    noise_prod;
    logic [PW-1:0]    noise_diff;
    logic [DIV_W-1:0] noise_period;
    logic             noise_silent;
    logic [DIV_W-1:0] noise_cnt;
    logic [15:0]      lfsr;
    logic             noise_bit;

    assign noise_prod   = PW'(rpm) * PW'(NOISE_SLOPE);
    assign noise_diff   = PW'(NOISE_BASE) - noise_prod;
    assign noise_silent = (rpm < RPM_W'(RPM_MIN));

    always_comb begin
        noise_period = DIV_W'(noise_diff);
        if ((noise_prod > PW'(NOISE_BASE)) || (noise_diff < PW'(NOISE_MIN)))
            noise_period = DIV_W'(NOISE_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            noise_cnt <= '0;
            lfsr      <= SEED;
            noise_bit <= 1'b0;
        end else if (noise_silent) begin
            noise_bit <= 1'b0;
        end else if (noise_cnt >= noise_period - D_ONE) begin
            // >= rather than == so a sudden rpm increase cannot strand the counter above the period.
            noise_cnt <= '0;
            noise_bit <= lfsr[0];
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end else begin
            noise_cnt <= noise_cnt + D_ONE;
        end
    end

    // Priority mixer: scanning downward lets the lowest active index overwrite the rest.
    logic            win_found;
    logic [CH_W-1:0] win_idx;
    logic            win_tone;
    logic            mix;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_tone  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (st[i] != S_IDLE) begin
                win_found = 1'b1;
                win_idx   = CH_W'(i);
                win_tone  = (st[i] == S_ON) && wave[i];
            end
        end
        mix = win_found ? win_tone : noise_bit;
    end

`ifdef SOUND_PWM_VOL_EN
    logic [3:0] pwm_cnt;
    logic       vol_gate;

    assign vol_gate = (pwm_cnt < vol);

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end
`else
    logic unused_vol;
    logic vol_gate;

    assign unused_vol = ^vol;
    assign vol_gate   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            piezo_out    <= 1'b0;
            active_valid <= 1'b0;
            active_ch    <= '0;
        end else begin
            piezo_out    <= mix & vol_gate;
            active_valid <= win_found;
            active_ch    <= win_idx;
        end
    end

endmodule

// File: tb/tb_sound_mixer_nch.sv
// Self-checking bench for sound_mixer_nch: directed scenarios plus randomized segments,
// compared every cycle against an elapsed-time reference model of channels, noise and mixer.
module tb_sound_mixer_nch;

    localparam int          N_CH        = 2;
    localparam int          DIV_W       = 20;
    localparam int          BURST_W     = 24;
    localparam int          RPM_W       = 14;
    localparam int          RPM_MIN     = 500;
    localparam int          NOISE_BASE  = 15000;
    localparam int          NOISE_SLOPE = 10;
    localparam int          NOISE_MIN   = 200;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [RPM_W-1:0]        rpm;
    logic [N_CH-1:0]         ch_req;
    logic [N_CH*DIV_W-1:0]   ch_half_period;
    logic [N_CH*BURST_W-1:0] ch_on_cyc;
    logic [N_CH*BURST_W-1:0] ch_off_cyc;
    logic [3:0]              vol;
    logic                    piezo_out;
    logic                    active_valid;
    logic [0:0]              active_ch;

    sound_mixer_nch #(
        .N_CH(N_CH), .DIV_W(DIV_W), .BURST_W(BURST_W), .RPM_W(RPM_W), .RPM_MIN(RPM_MIN),
        .NOISE_BASE(NOISE_BASE), .NOISE_SLOPE(NOISE_SLOPE), .NOISE_MIN(NOISE_MIN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .rpm(rpm), .ch_req(ch_req), .ch_half_period(ch_half_period),
        .ch_on_cyc(ch_on_cyc), .ch_off_cyc(ch_off_cyc), .vol(vol),
        .piezo_out(piezo_out), .active_valid(active_valid), .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each channel is "active for t cycles since its last ON entry" with latched settings.
    bit          m_act [N_CH];
    int unsigned m_t   [N_CH];
    int unsigned m_hp  [N_CH];
    int unsigned m_on  [N_CH];
    int unsigned m_off [N_CH];
    int unsigned m_ncnt;
    bit [15:0]   m_lfsr;
    bit          m_nb;
    bit [3:0]    m_pwm;
    logic        e_piezo;
    logic        e_valid;
    logic [0:0]  e_ch;

    function automatic bit m_wave(input int i);
        if (m_on[i] != 0 && m_t[i] >= m_on[i]) return 1'b0;
        if (m_hp[i] == 0) return 1'b0;
        return ((m_t[i] / m_hp[i]) % 2) == 1;
    endfunction

    function automatic int unsigned m_period(input int unsigned r);
        longint p;
        p = longint'(NOISE_BASE) - longint'(r) * NOISE_SLOPE;
        if (p < NOISE_MIN) p = NOISE_MIN;
        return int'(p);
    endfunction

    task automatic m_latch(input int i);
        m_t[i]   = 0;
        m_hp[i]  = ch_half_period[i*DIV_W +: DIV_W];
        m_on[i]  = ch_on_cyc[i*BURST_W +: BURST_W];
        m_off[i] = ch_off_cyc[i*BURST_W +: BURST_W];
    endtask

    task automatic model_edge();
        bit found;
        bit mix;
        bit fb;
        if (rst) begin
            e_piezo = 1'b0; e_valid = 1'b0; e_ch = 1'b0;
            for (int i = 0; i < N_CH; i++) begin m_act[i] = 1'b0; m_t[i] = 0; end
            m_ncnt = 0; m_lfsr = SEED; m_nb = 1'b0; m_pwm = 4'd0;
            return;
        end
        found = 1'b0;
        mix   = m_nb;
        e_ch  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (m_act[i] && !found) begin
                found = 1'b1;
                e_ch  = 1'(i);
                mix   = m_wave(i);
            end
        end
        e_valid = found;
`ifdef SOUND_PWM_VOL_EN
        e_piezo = mix && (m_pwm < vol);
`else
        e_piezo = mix;
`endif
        m_pwm = m_pwm + 4'd1;
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_req[i]) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
                m_act[i] = 1'b1;
                m_latch(i);
            end else begin
                m_t[i]++;
                if (m_on[i] != 0 && ((m_off[i] == 0 && m_t[i] == m_on[i]) ||
                                     (m_off[i] != 0 && m_t[i] == m_on[i] + m_off[i])))
                    m_latch(i);
            end
        end
        if (rpm < RPM_MIN) begin
            m_nb = 1'b0;
        end else if (m_ncnt + 1 >= m_period(rpm)) begin
            m_ncnt = 0;
            m_nb   = m_lfsr[0];
            fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
        end else begin
            m_ncnt++;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, " piezo_out"},    piezo_out,    e_piezo);
        check({tag, " active_valid"}, active_valid, e_valid);
        check({tag, " active_ch"},    active_ch[0], e_ch[0]);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic set_ch(input int i, input bit req, input int hp, input int on, input int off);
        ch_req[i]                        = req;
        ch_half_period[i*DIV_W +: DIV_W] = DIV_W'(hp);
        ch_on_cyc[i*BURST_W +: BURST_W]  = BURST_W'(on);
        ch_off_cyc[i*BURST_W +: BURST_W] = BURST_W'(off);
    endtask

    initial begin
        int first_hi;
        int gap_len;
        rst = 1'b1; rpm = '0; ch_req = '0; ch_half_period = '0;
        ch_on_cyc = '0; ch_off_cyc = '0; vol = 4'd15;

        // Reset with idle inputs
        run(3, "reset");
        check("reset piezo_out direct", piezo_out, 1'b0);
        check("reset active_valid direct", active_valid, 1'b0);
        rst = 1'b0;
        run(5, "idle");

        // Continuous tone on ch0: first rise 5 edges after the request-sampling edge
        set_ch(0, 1'b1, 4, 0, 0);
        first_hi = -1;
        for (int k = 0; k < 20; k++) begin
            tick("ch0_tone");
            if (piezo_out === 1'b1 && first_hi < 0) first_hi = k;
        end
        check_int("ch0 first toggle latency", first_hi, 5);
        run(30, "ch0_tone");
        set_ch(0, 1'b0, 4, 0, 0);
        run(4, "ch0_release");

        // Burst pattern on ch1: 10 on, 6 gap; measure the silent run directly
        set_ch(1, 1'b1, 3, 10, 6);
        run(12, "ch1_burst");
        gap_len = 0;
        for (int k = 0; k < 16; k++) begin
            tick("ch1_burst");
            if (active_valid === 1'b1 && piezo_out === 1'b0) gap_len++;
            else if (gap_len > 0 && gap_len < 6) gap_len = 100;
        end
        run(40, "ch1_burst");

        // Preemption by ch0, then handback to ch1 mid-pattern
        set_ch(0, 1'b1, 5, 0, 0);
        tick("preempt");
        tick("preempt");
        check_int("preempt active_ch", int'(active_ch), 0);
        run(25, "preempt");
        set_ch(0, 1'b0, 5, 0, 0);
        tick("handback");
        tick("handback");
        check_int("handback active_ch", int'(active_ch), 1);
        run(30, "handback");
        set_ch(1, 1'b0, 3, 10, 6);
        run(3, "ch1_release");

        // Engine noise: silence below RPM_MIN, then several period regimes
        rpm = 14'd400;   run(300,   "rpm400");
        rpm = 14'd1000;  run(16000, "rpm1000");
        rpm = 14'd16000; run(4000,  "rpm16000");
        rpm = 14'd1480;  run(1000,  "rpm1480");
        rpm = 14'd1470;  run(1000,  "rpm1470");
        rpm = 14'd499;   run(200,   "rpm499");
        rpm = 14'd500;   run(15000, "rpm500");

        // Half-period of zero owns the output but stays silent
        rpm = 14'd16000;
        set_ch(0, 1'b1, 0, 0, 0);
        run(40, "hp0");
        check("hp0 piezo direct", piezo_out, 1'b0);
        check("hp0 valid direct", active_valid, 1'b1);

        // Randomized segments, including setting changes while channels run
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < N_CH; i++)
                set_ch(i, $urandom_range(0, 3) != 0, $urandom_range(0, 6),
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12),
                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8));
            rpm = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 499)) : 14'($urandom_range(500, 16383));
            vol = 4'($urandom_range(0, 15));
            run($urandom_range(30, 300), "random");
        end

        // Reset asserted mid-operation
        set_ch(0, 1'b1, 2, 5, 3);
        set_ch(1, 1'b1, 3, 0, 0);
        run(20, "pre_reset");
        rst = 1'b1;
        tick("mid_reset");
        check("mid_reset valid direct", active_valid, 1'b0);
        check("mid_reset piezo direct", piezo_out, 1'b0);
        rst = 1'b0;
        run(60, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
